pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter for the ALU shift path. Generalises the fixed
//  2^k left-shift stages to WIDTH bits and adds four shift modes (SLL/SRL/SRA/ROL).
//  One registered log-stage per shift-amount bit. Valid/ready handshake on both sides.

---
 rtl/pipelined_barrel_shifter.sv | 138 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered log-stage per shift-amount bit, SLL/SRL/SRA/ROL,
// valid/ready on both sides with a collapsing-bubble ready chain and a sideband tag.
module pbs_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5,
  parameter int K       = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ld_i,
  input  logic               vld_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  input  logic               sign_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               vld_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [1:0]         op_o,
  output logic               sign_o,
  output logic [TAG_W-1:0]   tag_o
);
  localparam int S = 1 << K;

  logic               vld_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         op_q;
  logic               sign_q;
  logic [TAG_W-1:0]   tag_q;

  always_comb begin
    data_d = data_i;
    if (shamt_i[K]) begin
      case (op_i)
        2'b00:   data_d = data_i << S;
        2'b01:   data_d = data_i >> S;
        2'b10:   data_d = (data_i >> S) | (sign_i ? ~({WIDTH{1'b1}} >> S) : '0);
        default: data_d = (data_i << S) | (data_i >> (WIDTH - S));
      endcase
    end
  end

  // Payload only moves with a valid op, so empty stages hold their last contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
    end else if (ld_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        data_q  <= data_d;
        shamt_q <= shamt_i;
        op_q    <= op_i;
        sign_q  <= sign_i;
        tag_q   <= tag_i;
      end
    end
  end

  assign vld_o   = vld_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign sign_o  = sign_q;
  assign tag_o   = tag_q;
endmodule

module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic [TAG_W-1:0]   tag_out
);
  // Index 0 is the request port; index k+1 is the output of stage k.
  logic [SHAMT_W:0]              vld_pipe;
  logic [SHAMT_W:0][WIDTH-1:0]   dat_pipe;
  logic [SHAMT_W:0][SHAMT_W-1:0] sh_pipe;
  logic [SHAMT_W:0][1:0]         op_pipe;
  logic [SHAMT_W:0]              sgn_pipe;
  logic [SHAMT_W:0][TAG_W-1:0]   tag_pipe;
  logic [SHAMT_W-1:0]            ld;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = data_in;
  assign sh_pipe[0]  = shamt;
  assign op_pipe[0]  = op;
  assign sgn_pipe[0] = data_in[WIDTH-1];
  assign tag_pipe[0] = tag_in;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    // A stage advances when any stage from it to the tail has a hole, or the sink drains.
    assign ld[k] = out_ready | ~(&vld_pipe[SHAMT_W:k+1]);

    pbs_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W), .K(k)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .ld_i    (ld[k]),
      .vld_i   (vld_pipe[k]),
      .data_i  (dat_pipe[k]),
      .shamt_i (sh_pipe[k]),
      .op_i    (op_pipe[k]),
      .sign_i  (sgn_pipe[k]),
      .tag_i   (tag_pipe[k]),
      .vld_o   (vld_pipe[k+1]),
      .data_o  (dat_pipe[k+1]),
      .shamt_o (sh_pipe[k+1]),
      .op_o    (op_pipe[k+1]),
      .sign_o  (sgn_pipe[k+1]),
      .tag_o   (tag_pipe[k+1])
    );
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_pipe[SHAMT_W];
  assign data_out  = dat_pipe[SHAMT_W];
  assign tag_out   = tag_pipe[SHAMT_W];

  wire unused_tail = ^{sh_pipe[SHAMT_W], op_pipe[SHAMT_W], sgn_pipe[SHAMT_W]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: latency, modes, backpressure, random stream, reset.
module tb_pipelined_barrel_shifter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  op = '0;
  logic [4:0]  tag_in = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] data_out;
  logic [4:0]  tag_out;

  int checks = 0, errors = 0;

  pipelined_barrel_shifter dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shamt(shamt), .op(op), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .tag_out(tag_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return (d << s) | (d >> (6'd32 - {1'b0, s}));
    endcase
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Single op with out_ready=1: check 5-edge latency and a one-cycle result pulse.
  task automatic send_one(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] o, input logic [4:0] t, input logic [31:0] exp);
    in_valid = 1'b1; data_in = d; shamt = s; op = o; tag_in = t; out_ready = 1'b1;
    #1 chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk({name, "_early"}, {31'b0, out_valid}, 32'd0);
    step();
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_data"}, data_out, exp);
    chk({name, "_tag"}, {27'b0, tag_out}, {27'b0, t});
    step();
    chk({name, "_pulse"}, {31'b0, out_valid}, 32'd0);
  endtask

  // Streaming harness: scoreboard queue, in-order compare, hold-stability check.
  logic [31:0] nd;
  logic [4:0]  nsh, ntag;
  logic [1:0]  nop;
  logic [36:0] q[$];
  logic        hold = 1'b0;
  logic [31:0] hd;
  logic [4:0]  ht;
  int          npop = 0;

  task automatic cycle(input logic iv, input logic ordy, output logic acc);
    logic        ov;
    logic [31:0] od;
    logic [4:0]  ot;
    logic [36:0] e;
    in_valid = iv; data_in = nd; shamt = nsh; op = nop; tag_in = ntag; out_ready = ordy;
    #1;
    acc = iv & in_ready;
    ov = out_valid; od = data_out; ot = tag_out;
    if (hold) begin
      chk("hold_valid", {31'b0, ov}, 32'd1);
      chk("hold_data", od, hd);
      chk("hold_tag", {27'b0, ot}, {27'b0, ht});
    end
    hold = ov & ~ordy; hd = od; ht = ot;
    if (ov && ordy) begin
      if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("res_data", od, e[36:5]);
        chk("res_tag", {27'b0, ot}, {27'b0, e[4:0]});
      end
      npop++;
    end
    if (acc) q.push_back({model(nd, nsh, nop), ntag});
    @(posedge clock); #1;
  endtask

  initial begin
    logic acc;
    int   i, cyc, pushed;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_tag", {27'b0, tag_out}, 32'd0);
    step(); step();
    reset = 1'b0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    // Directed modes
    send_one("sll8",   32'h000000FF, 5'd8,  2'b00, 5'd3,  32'h0000FF00);
    send_one("sra31",  32'h80000000, 5'd31, 2'b10, 5'd1,  32'hFFFFFFFF);
    send_one("srl31",  32'h80000000, 5'd31, 2'b01, 5'd2,  32'h00000001);
    send_one("sll31",  32'h80000000, 5'd31, 2'b00, 5'd4,  32'h00000000);
    send_one("rol4",   32'h80000001, 5'd4,  2'b11, 5'd5,  32'h00000018);
    send_one("rol0",   32'h80000001, 5'd0,  2'b11, 5'd6,  32'h80000001);
    send_one("sra4",   32'hF0000000, 5'd4,  2'b10, 5'd7,  32'hFF000000);
    send_one("sra_pos",32'h7FFFFFFF, 5'd30, 2'b10, 5'd8,  32'h00000001);

    // Backpressure: fill with out_ready=0, then drain in order
    i = 0;
    for (int c = 0; c < 7; c++) begin
      nd = 32'hA5A50000 + i; nsh = 5'(i * 3); nop = 2'(i); ntag = 5'(i);
      cycle(1'b1, 1'b0, acc);
      if (acc) i++;
    end
    chk("fill_accepts", i, 32'd5);
    out_ready = 1'b0; #1;
    chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
    chk("fill_out_valid", {31'b0, out_valid}, 32'd1);
    npop = 0; cyc = 0;
    while ((npop < 8) && (cyc < 40)) begin
      nd = 32'hA5A50000 + i; nsh = 5'(i * 3); nop = 2'(i); ntag = 5'(i);
      cycle(i < 8, 1'b1, acc);
      if (acc) i++;
      cyc++;
    end
    chk("drain_count", npop, 32'd8);

    // Random stream with out_ready toggling
    pushed = 0; cyc = 0; npop = 0;
    while (((pushed < 1000) || (q.size() != 0)) && (cyc < 6000)) begin
      nd = $urandom; nsh = 5'($urandom_range(0, 31)); nop = 2'($urandom_range(0, 3));
      ntag = 5'(pushed);
      cycle((pushed < 1000) && ($urandom_range(0, 1) == 1), cyc[0], acc);
      if (acc) pushed++;
      cyc++;
    end
    chk("stream_pushed", pushed, 32'd1000);
    chk("stream_popped", npop, 32'd1000);

    // Reset with ops in flight
    nd = 32'h12345678; nsh = 5'd1; nop = 2'b00; ntag = 5'd9;
    repeat (3) cycle(1'b1, 1'b0, acc);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_tag", {27'b0, tag_out}, 32'd0);
    q.delete(); hold = 1'b0;
    step();
    reset = 1'b0;
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 chk("post_rst_quiet", {31'b0, out_valid}, 32'd0);
      step();
    end
    send_one("post_rst", 32'h00000001, 5'd1, 2'b00, 5'd10, 32'h00000002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
